imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter and sequencer for the byte-addressed, combinational-read instruction memory. It shares the single memory read port between the core fetch stage and the debug/loader port. It registers each read into a held response with a one-cycle issue-to-response latency, and flags misaligned or out-of-range addresses. It sits between the fetch stage / debug unit and the instruction memory.

## Interface
- N, default defines::N (32): address and instruction width.
- INST_MEM_SIZE, default defines::INST_MEM_SIZE: memory size in bytes.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req_valid  in  1  fetch read request.
- f_req_addr  in  N  fetch byte address.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_rsp_valid  out  1  fetch response held.
- f_rsp_ready  in  1  fetch consumes the response.
- f_rsp_data  out  N  instruction word.
- f_rsp_err  out  1  address error.
- d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_data, d_rsp_err: the same ports for the debug requester.
- mem_addr  out  N  address to the instruction memory, driven combinationally.
- mem_instruction  in  N  memory read data, combinational from mem_addr.
- f_stall_cnt  out  16  saturating count of fetch stall cycles.

## Operation
- FSM states and response ownership:
  - IDLE: no response held.
  - RESP_F: a response is held for fetch.
  - RESP_D: a response is held for debug.
- Issue window:
  - Open in IDLE.
  - Open in RESP_x during the cycle the held response is consumed (x_rsp_valid && x_rsp_ready).
  - Closed otherwise; both req_ready outputs are 0.
- Grant:
  - Requires an open window and at least one req_valid.
  - Exactly one requester is granted. Its req_ready is 1 and mem_addr carries its address.
  - When nothing is granted, mem_addr is driven with 0.
- Capture on a grant edge:
  - rsp_data is loaded with mem_instruction.
  - err is 0 or 1 as defined by the error rule below.
  - The state moves to RESP_F or RESP_D according to the grant.
  - If the window was open only because of a consume and there is no grant, the state returns to IDLE.
- Error rule:
  - err = 1 when addr[1:0] != 0 or addr > INST_MEM_SIZE-4.
  - On error, rsp_data is 0 and the request still completes with a response.
- Hold rule: rsp_data and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- Requester rule: a requester holds req_valid and req_addr until req_ready.
- Stall counter:
  - Increments on every cycle with f_req_valid && !f_req_ready.
  - Saturates at 16'hFFFF.
  - Never wraps.

## Timing
- Reset values: state IDLE, all rsp_valid 0, rsp_data 0, rsp_err 0, f_stall_cnt 0, round-robin pointer set to favor fetch.
- Reset mid-operation drops any held response immediately; no response is produced for it after reset.
- Latency: request handshake in cycle T gives rsp_valid=1 in cycle T+1.
- Throughput: one response per cycle per port pair when rsp_ready is held at 1. A new grant in the consume cycle produces back-to-back responses.
- Simultaneous req_valid on both ports: a single grant, decided by the arbitration policy below.
- A consume and a new request from the same port in the same cycle are both allowed.
- f_req_ready and d_req_ready depend combinationally on rsp_ready; there is no combinational path from req to rsp.

## Configuration
- IMEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - On a tie, the grant goes to the port not granted most recently.
  - The pointer updates only on a grant.
  - After reset the pointer favors fetch.
- IMEM_ARB_RR_EN undefined:
  - Fixed priority, fetch over debug.
  - Debug is granted only when f_req_valid=0 in an open window.
  - Debug starvation is allowed by design.

## Test plan
- Reset, then memory holding 32'h8001000A at 0 and 32'h04011800 at 4; fetch reads 0 then 4 with rsp_ready=1. Required: rsp_valid in cycles T+1 and T+2, data 8001000A then 04011800, err=0.
- Fetch addr 2 -> err=1, data 0. Fetch addr INST_MEM_SIZE (aligned) -> err=1, data 0.
- Both ports request addr 0 continuously with rsp_ready=1. RR build: grants alternate F, D, F, D. Fixed build: F only, d_req_ready=0 throughout.
- Fetch response held with f_rsp_ready=0 for 3 cycles while a new request is pending. Required: data stable, f_req_ready=0, f_stall_cnt +3; the new request is granted in the consume cycle.
- Assert rst while RESP_D is held. Required: d_rsp_valid=0 immediately, no response after reset release.
- Hold fetch stalled for 70000 cycles. Required: f_stall_cnt = 16'hFFFF and holds.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single combinational-read instruction memory port
// between the fetch stage (f_*) and the debug/loader port (d_*). Each granted
// read is captured into a held response one cycle after the request handshake.
// Misaligned or out-of-range addresses complete with err=1 and data 0.
//
// Configuration macro IMEM_ARB_RR_EN:
//   defined   -> round-robin arbitration on simultaneous requests
//   undefined -> fixed priority, fetch over debug (debug may starve)
module imem_arbiter #(
  parameter int N             = 32,
  parameter int INST_MEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  // fetch requester
  input  logic         f_req_valid,
  input  logic [N-1:0] f_req_addr,
  output logic         f_req_ready,
  output logic         f_rsp_valid,
  input  logic         f_rsp_ready,
  output logic [N-1:0] f_rsp_data,
  output logic         f_rsp_err,
  // debug/loader requester
  input  logic         d_req_valid,
  input  logic [N-1:0] d_req_addr,
  output logic         d_req_ready,
  output logic         d_rsp_valid,
  input  logic         d_rsp_ready,
  output logic [N-1:0] d_rsp_data,
  output logic         d_rsp_err,
  // instruction memory read port
  output logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_instruction,
  // statistics
  output logic [15:0]  f_stall_cnt
);

  // Highest byte address at which a whole word still fits in the memory.
  localparam logic [N-1:0] LAST_WORD_ADDR = N'(INST_MEM_SIZE - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } state_e;

  // Address is unusable when not word aligned or when the word runs past the end.
  function automatic logic addr_err(input logic [N-1:0] addr);
    addr_err = (addr[1:0] != 2'b00) || (addr > LAST_WORD_ADDR);
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   f_rsp_data_q, f_rsp_data_d;
  logic [N-1:0]   d_rsp_data_q, d_rsp_data_d;
  logic           f_rsp_err_q, f_rsp_err_d;
  logic           d_rsp_err_q, d_rsp_err_d;
  logic [15:0]    f_stall_cnt_q, f_stall_cnt_d;

  logic           consume_s;
  logic           window_s;
  logic           grant_f_s;
  logic           grant_d_s;
  logic [N-1:0]   grant_addr_s;
  logic           grant_err_s;

`ifdef IMEM_ARB_RR_EN
  // 1 = debug was granted most recently, so fetch wins the next tie.
  logic           last_d_q, last_d_d;
`endif

  // Issue window: open when nothing is held or the held response leaves this cycle.
  always_comb begin
    consume_s = 1'b0;
    case (state_q)
      RESP_F:  consume_s = f_rsp_ready;
      RESP_D:  consume_s = d_rsp_ready;
      IDLE:    consume_s = 1'b0;
      default: consume_s = 1'b0;
    endcase
    window_s = (state_q == IDLE) || consume_s;
  end

  // Arbitration: at most one requester is granted per open window.
  always_comb begin
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    if (window_s) begin
`ifdef IMEM_ARB_RR_EN
      if (f_req_valid && d_req_valid) begin
        grant_f_s = last_d_q;
        grant_d_s = !last_d_q;
      end else begin
        grant_f_s = f_req_valid;
        grant_d_s = d_req_valid;
      end
`else
      grant_f_s = f_req_valid;
      grant_d_s = d_req_valid && !f_req_valid;
`endif
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Memory address mux and the error flag for the granted address.
  always_comb begin
    grant_addr_s = {N{1'b0}};
    if (grant_f_s) begin
      grant_addr_s = f_req_addr;
    end else if (grant_d_s) begin
      grant_addr_s = d_req_addr;
    end else begin
      grant_addr_s = {N{1'b0}};
    end
    grant_err_s = addr_err(grant_addr_s);
  end

  assign mem_addr    = grant_addr_s;
  assign f_req_ready = grant_f_s;
  assign d_req_ready = grant_d_s;

  // Next-state, response capture and ownership transitions.
  always_comb begin
    state_d      = state_q;
    f_rsp_data_d = f_rsp_data_q;
    f_rsp_err_d  = f_rsp_err_q;
    d_rsp_data_d = d_rsp_data_q;
    d_rsp_err_d  = d_rsp_err_q;
    if (grant_f_s) begin
      state_d      = RESP_F;
      f_rsp_err_d  = grant_err_s;
      f_rsp_data_d = grant_err_s ? {N{1'b0}} : mem_instruction;
    end else if (grant_d_s) begin
      state_d      = RESP_D;
      d_rsp_err_d  = grant_err_s;
      d_rsp_data_d = grant_err_s ? {N{1'b0}} : mem_instruction;
    end else if (consume_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Round-robin pointer moves only when someone is granted.
  always_comb begin
    last_d_d = last_d_q;
    if (grant_f_s) begin
      last_d_d = 1'b0;
    end else if (grant_d_s) begin
      last_d_d = 1'b1;
    end else begin
      last_d_d = last_d_q;
    end
  end

  // Round-robin pointer register; reset favours fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // Saturating count of cycles where fetch asks but is not accepted.
  always_comb begin
    f_stall_cnt_d = f_stall_cnt_q;
    if (f_req_valid && !grant_f_s && (f_stall_cnt_q != 16'hFFFF)) begin
      f_stall_cnt_d = f_stall_cnt_q + 16'd1;
    end else begin
      f_stall_cnt_d = f_stall_cnt_q;
    end
  end

  // State, held responses and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      f_rsp_data_q  <= {N{1'b0}};
      f_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= {N{1'b0}};
      d_rsp_err_q   <= 1'b0;
      f_stall_cnt_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      f_rsp_data_q  <= f_rsp_data_d;
      f_rsp_err_q   <= f_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
      d_rsp_err_q   <= d_rsp_err_d;
      f_stall_cnt_q <= f_stall_cnt_d;
    end
  end

  assign f_rsp_valid = (state_q == RESP_F);
  assign d_rsp_valid = (state_q == RESP_D);
  assign f_rsp_data  = f_rsp_data_q;
  assign f_rsp_err   = f_rsp_err_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign f_stall_cnt = f_stall_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter. Expectations follow the
// arbitration build selected by IMEM_ARB_RR_EN.
module tb_imem_arbiter;

  localparam int N        = 32;
  localparam int MEM_SIZE = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [N-1:0] f_req_addr, f_rsp_data;
  logic         d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [N-1:0] d_req_addr, d_rsp_data;
  logic [N-1:0] mem_addr, mem_instruction;
  logic [15:0]  f_stall_cnt;

  logic [31:0]  mem [0:255];
  int           errors = 0;
  int           checks = 0;
  int           exp_stall;
  logic         exp_f;

`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  imem_arbiter #(.N(N), .INST_MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_instruction(mem_instruction),
    .f_stall_cnt(f_stall_cnt)
  );

  always #5 clk = ~clk;

  // Combinational memory model; out-of-range reads return a poison pattern.
  assign mem_instruction = (mem_addr < MEM_SIZE) ? mem[mem_addr[9:2]] : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read from one port with rsp_ready=1, then back to idle.
  task automatic read_one(input bit dbg, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    if (dbg) begin d_req_valid = 1'b1; d_req_addr = addr; end
    else     begin f_req_valid = 1'b1; f_req_addr = addr; end
    #1;
    check("req_ready", dbg ? d_req_ready : f_req_ready, 32'd1);
    check("mem_addr", mem_addr, addr);
    step();
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1;
    check("rsp_valid", dbg ? d_rsp_valid : f_rsp_valid, 32'd1);
    check("rsp_data", dbg ? d_rsp_data : f_rsp_data, exp_data);
    check("rsp_err", dbg ? d_rsp_err : f_rsp_err, exp_err);
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 + i;
    mem[0]   = 32'h8001000A;
    mem[1]   = 32'h04011800;
    mem[255] = 32'hCAFEF00D;
    rst = 1'b1;
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = '0; d_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_valid", f_rsp_valid, 32'd0);
    check("rst_d_valid", d_rsp_valid, 32'd0);
    check("rst_f_data", f_rsp_data, 32'd0);
    check("rst_d_data", d_rsp_data, 32'd0);
    check("rst_f_err", f_rsp_err, 32'd0);
    check("rst_stall", f_stall_cnt, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back fetch of 0 then 4.
    f_req_valid = 1'b1; f_req_addr = 32'd0;
    #1;
    check("b2b_ready0", f_req_ready, 32'd1);
    step();
    f_req_addr = 32'd4;
    #1;
    check("b2b_valid0", f_rsp_valid, 32'd1);
    check("b2b_data0", f_rsp_data, 32'h8001000A);
    check("b2b_err0", f_rsp_err, 32'd0);
    check("b2b_ready1", f_req_ready, 32'd1);
    check("b2b_addr1", mem_addr, 32'd4);
    step();
    f_req_valid = 1'b0;
    #1;
    check("b2b_valid1", f_rsp_valid, 32'd1);
    check("b2b_data1", f_rsp_data, 32'h04011800);
    step();
    check("b2b_idle", f_rsp_valid, 32'd0);
    check("b2b_stall", f_stall_cnt, 32'd0);

    // Error and boundary addresses.
    read_one(1'b0, 32'd2, 32'd0, 1'b1);
    read_one(1'b0, MEM_SIZE, 32'd0, 1'b1);
    read_one(1'b0, MEM_SIZE - 4, 32'hCAFEF00D, 1'b0);
    read_one(1'b0, MEM_SIZE - 3, 32'd0, 1'b1);
    // Debug read; leaves the round-robin pointer favouring fetch.
    read_one(1'b1, 32'd4, 32'h04011800, 1'b0);

    // Both ports request continuously.
    f_req_valid = 1'b1; f_req_addr = 32'd0;
    d_req_valid = 1'b1; d_req_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_f = RR ? (i % 2 == 0) : 1'b1;
      if (i > 0) begin
        check("tie_f_rsp", f_rsp_valid, (RR ? (i % 2 == 1) : 1'b1));
        check("tie_d_rsp", d_rsp_valid, (RR ? (i % 2 == 0) : 1'b0));
      end
      check("tie_f_ready", f_req_ready, exp_f);
      check("tie_d_ready", d_req_ready, !exp_f);
      step();
    end
    f_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1;
    check("tie_last_f", f_rsp_valid, RR ? 32'd0 : 32'd1);
    check("tie_last_d", d_rsp_valid, RR ? 32'd1 : 32'd0);
    check("tie_last_data", RR ? d_rsp_data : f_rsp_data, 32'h8001000A);
    step();
    check("tie_idle", f_rsp_valid | d_rsp_valid, 32'd0);
    exp_stall = RR ? 2 : 0;
    check("tie_stall", f_stall_cnt, exp_stall);

    // Held fetch response with a pending request.
    f_rsp_ready = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'd0;
    #1;
    check("hold_ready0", f_req_ready, 32'd1);
    step();
    f_req_addr = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", f_req_ready, 32'd0);
      check("hold_valid", f_rsp_valid, 32'd1);
      check("hold_data", f_rsp_data, 32'h8001000A);
      step();
    end
    f_rsp_ready = 1'b1;
    #1;
    check("hold_consume_ready", f_req_ready, 32'd1);
    check("hold_stall", f_stall_cnt, exp_stall + 3);
    step();
    f_req_valid = 1'b0;
    #1;
    check("hold_next_valid", f_rsp_valid, 32'd1);
    check("hold_next_data", f_rsp_data, 32'h04011800);
    check("hold_stall_after", f_stall_cnt, exp_stall + 3);
    step();

    // Reset while a debug response is held.
    d_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'd4;
    step();
    d_req_valid = 1'b0;
    #1;
    check("rstmid_held", d_rsp_valid, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_valid", d_rsp_valid, 32'd0);
    check("rstmid_data", d_rsp_data, 32'd0);
    check("rstmid_stall", f_stall_cnt, 32'd0);
    step();
    rst = 1'b0;
    d_rsp_ready = 1'b1;
    step();
    step();
    check("rstmid_after_d", d_rsp_valid, 32'd0);
    check("rstmid_after_f", f_rsp_valid, 32'd0);

    // Long fetch stall: counter climbs then saturates.
    f_rsp_ready = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'd0;
    step();
    repeat (100) step();
    check("stall_100", f_stall_cnt, 32'd100);
    repeat (69900) step();
    check("stall_sat", f_stall_cnt, 32'h0000FFFF);
    check("stall_ready", f_req_ready, 32'd0);
    repeat (3) step();
    check("stall_sat_hold", f_stall_cnt, 32'h0000FFFF);
    f_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
